// File: rtl/i2s_tdm_transceiver_if.sv
// Bus between the I2S/TDM transceiver and its surroundings: codec pins plus the
// transmit valid/ready and receive valid-strobe handshakes.
interface i2s_tdm_transceiver_if #(
  parameter int CHANNELS = 2,
  parameter int D_WIDTH  = 24
);
  // Handshake: a tx frame is taken only at a frame wrap. If tx_valid is high,
  // tx_data is captured and tx_ready pulses for one mclk. Otherwise zeros are
  // sent and tx_underrun pulses. rx_valid pulses once per frame and rx_data
  // stays stable until the next pulse.
  logic                         sclk;
  logic                         ws;
  logic                         sd_tx;
  logic                         sd_rx;
  logic [CHANNELS*D_WIDTH-1:0]  tx_data;
  logic                         tx_valid;
  logic                         tx_ready;
  logic                         tx_underrun;
  logic [CHANNELS*D_WIDTH-1:0]  rx_data;
  logic                         rx_valid;

  modport master (
    output sclk, ws, sd_tx, tx_ready, tx_underrun, rx_data, rx_valid,
    input  sd_rx, tx_data, tx_valid
  );

  modport slave (
    input  sclk, ws, sd_tx, tx_ready, tx_underrun, rx_data, rx_valid,
    output sd_rx, tx_data, tx_valid
  );
endinterface

// File: rtl/i2s_tdm_transceiver.sv
// I2S/TDM master transceiver: divides mclk into sclk/ws, serialises and
// deserialises CHANNELS words per frame. Define I2S_LOOPBACK_EN for the loopback port.
module i2s_tdm_transceiver #(
  parameter int MCLK_SCLK_RATIO = 4,
  parameter int SLOT_WIDTH      = 32,
  parameter int CHANNELS        = 2,
  parameter int D_WIDTH         = 24
) (
  input  logic mclk,
  input  logic reset_n,
`ifdef I2S_LOOPBACK_EN
  input  logic loopback,
`endif
  i2s_tdm_transceiver_if.master bus
);

  localparam int FRAME = CHANNELS * SLOT_WIDTH;
  localparam int FW    = CHANNELS * D_WIDTH;
  localparam int CW    = $clog2(MCLK_SCLK_RATIO);
  localparam int BW    = $clog2(FRAME);
  localparam int PW    = $clog2(SLOT_WIDTH);
  localparam int CHW   = $clog2(CHANNELS);
  localparam int IW    = (FW > 1) ? $clog2(FW) : 1;

  localparam logic [CW-1:0]  CNT_LAST  = CW'(MCLK_SCLK_RATIO - 1);
  localparam logic [CW-1:0]  CNT_RISE  = CW'(MCLK_SCLK_RATIO / 2 - 1);
  localparam logic [CW-1:0]  CNT_HALF  = CW'(MCLK_SCLK_RATIO / 2);
  localparam logic [BW-1:0]  BIT_LAST  = BW'(FRAME - 1);
  localparam logic [BW-1:0]  BIT_SLOT  = BW'(SLOT_WIDTH);
  localparam logic [PW-1:0]  POS_LAST  = PW'(SLOT_WIDTH - 1);
  localparam logic [PW-1:0]  POS_DLAST = PW'(D_WIDTH);
  localparam logic [CHW-1:0] SLOT_LAST = CHW'(CHANNELS - 1);

  logic [CW-1:0]  mclk_cnt_q, mclk_cnt_d;
  logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CHW-1:0] slot_q, slot_d;
  logic [PW-1:0]  pos_q, pos_d;
  logic           sclk_q, ws_q, sd_tx_q;
  logic           tx_ready_q, tx_underrun_q, rx_valid_q;
  logic [FW-1:0]  tx_frame_q, rx_asm_q, rx_data_q;

  logic           fall_edge, rise_edge, wrap;
  logic           ws_d, tx_bit_d, tx_is_data, rx_is_data, rx_in;
  logic [IW-1:0]  tx_idx, rx_idx;

`ifdef I2S_LOOPBACK_EN
  assign rx_in = loopback ? sd_tx_q : bus.sd_rx;
`else
  assign rx_in = bus.sd_rx;
`endif

  // slot_q/pos_q track bit_cnt_q as (slot, position-in-slot) so no divider is needed
  always_comb begin
    fall_edge  = (mclk_cnt_q == CNT_LAST);
    rise_edge  = (mclk_cnt_q == CNT_RISE);
    wrap       = fall_edge && (bit_cnt_q == BIT_LAST);
    mclk_cnt_d = fall_edge ? '0 : mclk_cnt_q + 1'b1;
    bit_cnt_d  = bit_cnt_q;
    slot_d     = slot_q;
    pos_d      = pos_q;
    if (fall_edge) begin
      bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
      if (pos_q == POS_LAST) begin
        pos_d  = '0;
        slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
      end else begin
        pos_d  = pos_q + 1'b1;
      end
    end

    if (CHANNELS == 2) begin
      ws_d = (bit_cnt_d >= BIT_SLOT);
    end else begin
      ws_d = (bit_cnt_d == '0);
    end

    // One-bit delay: slot position 1 carries the MSB, position D_WIDTH the LSB
    tx_is_data = (pos_d != '0) && (pos_d <= POS_DLAST);
    tx_idx     = IW'(int'(slot_d) * D_WIDTH + D_WIDTH - int'(pos_d));
    tx_bit_d   = tx_is_data ? tx_frame_q[tx_idx] : 1'b0;

    rx_is_data = (pos_q != '0) && (pos_q <= POS_DLAST);
    rx_idx     = IW'(int'(slot_q) * D_WIDTH + D_WIDTH - int'(pos_q));
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      mclk_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      slot_q        <= '0;
      pos_q         <= '0;
      sclk_q        <= 1'b0;
      ws_q          <= 1'b0;
      sd_tx_q       <= 1'b0;
      tx_ready_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      rx_valid_q    <= 1'b0;
      tx_frame_q    <= '0;
      rx_asm_q      <= '0;
      rx_data_q     <= '0;
    end else begin
      mclk_cnt_q    <= mclk_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      slot_q        <= slot_d;
      pos_q         <= pos_d;
      sclk_q        <= (mclk_cnt_d >= CNT_HALF);
      ws_q          <= ws_d;
      if (fall_edge) begin
        sd_tx_q <= tx_bit_d;
      end
      tx_ready_q    <= wrap & bus.tx_valid;
      tx_underrun_q <= wrap & ~bus.tx_valid;
      rx_valid_q    <= wrap;
      // The frame captured here starts at bit 0, which is always padding
      if (wrap) begin
        tx_frame_q <= bus.tx_valid ? bus.tx_data : '0;
        rx_data_q  <= rx_asm_q;
      end
      if (rise_edge && rx_is_data) begin
        rx_asm_q[rx_idx] <= rx_in;
      end
    end
  end

  assign bus.sclk        = sclk_q;
  assign bus.ws          = ws_q;
  assign bus.sd_tx       = sd_tx_q;
  assign bus.tx_ready    = tx_ready_q;
  assign bus.tx_underrun = tx_underrun_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;

endmodule
